// File: rtl/sram_ctrl_param.sv
// sram_ctrl_param: single 32-bit load/store controller for an asynchronous SRAM,
// with a 16- or 32-bit data bus and a configurable number of clock cycles per beat.
module sram_ctrl_param #(
   parameter int SRAM_DW     = 16,
   parameter int SRAM_AW     = 18,
   parameter int WAIT_CYCLES = 2,
   parameter int BASE_ADDR   = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               ready,
   inout  wire  [SRAM_DW-1:0] sram_dq,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic               sram_we_n,
   output logic               sram_oe_n,
   output logic               sram_ce_n
);
   localparam int BEATS = 32 / SRAM_DW;
   localparam int WW = $clog2(WAIT_CYCLES);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state_q, state_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic beat_q, beat_d, rd_q, rd_d;
   logic [31:0] off_q, off_d, wdata_q, wdata_d, rdata_q, rdata_d, lane;
   logic [4:0] sh;
   logic last_cyc, last_beat, acc, wr_drive;
   // beat selects the 16-bit half of the word; with a 32-bit bus it stays 0
   assign sh        = {beat_q, 4'b0};
   assign lane      = 32'({SRAM_DW{1'b1}}) << sh;
   assign last_cyc  = wcnt_q == WW'(WAIT_CYCLES - 1);
   assign last_beat = beat_q == 1'(BEATS - 1);
   assign acc       = state_q == ACCESS;
   assign wr_drive  = acc && !rd_q;
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      beat_d  = beat_q;
      rd_d    = rd_q;
      off_d   = off_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (rd_en || wr_en) begin
            state_d = ACCESS;
            rd_d    = rd_en;
            off_d   = (addr - 32'(BASE_ADDR)) >> 2;
            wdata_d = wdata;
         end
         ACCESS: begin
            wcnt_d = last_cyc ? '0 : wcnt_q + 1'b1;
            if (last_cyc) begin
               beat_d  = last_beat ? 1'b0 : beat_q + 1'b1;
               rdata_d = rd_q ? (rdata_q & ~lane) | ((32'(sram_dq) << sh) & lane) : rdata_q;
               state_d = last_beat ? DONE : ACCESS;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         beat_q  <= 1'b0;
         rd_q    <= 1'b0;
         off_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         beat_q  <= beat_d;
         rd_q    <= rd_d;
         off_q   <= off_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end
   assign rdata     = rdata_q;
   assign ready     = !(acc || (state_q == IDLE && (rd_en || wr_en)));
   assign sram_ce_n = !acc;
   assign sram_oe_n = !(acc && rd_q);
   // last cycle of each write beat is a hold cycle with we_n released
   assign sram_we_n = !(wr_drive && !last_cyc);
   assign sram_addr = SRAM_AW'((off_q << (BEATS - 1)) | 32'(beat_q));
   assign sram_dq   = wr_drive ? SRAM_DW'(wdata_q >> sh) : 'z;
endmodule

// File: tb/tb_sram_ctrl_param.sv
// tb_sram_ctrl_param: random loads/stores against a word-level reference model;
// a monitor checks every SRAM cycle and each completion against a scoreboard queue.
module tb_sram_ctrl_param;
   localparam int W = 2, BEATS = 2, N = BEATS * W;
   typedef struct {
      bit          rd;
      logic [31:0] a;
      logic [31:0] d;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1;
   logic rd_en, wr_en, rd2;
   logic [31:0] addr, wdata, addr2, rdata, rdata2;
   logic ready, ready2, sram_we_n, sram_oe_n, sram_ce_n, we2_n, oe2_n, ce2_n;
   logic [17:0] sram_addr, sa2;
   tri1 [15:0] sram_dq;
   tri1 [31:0] dq2;
   logic [15:0] mem16 [0:262143];
   logic [31:0] mem32 [0:262143];
   logic [31:0] ref_m [int unsigned];
   exp_t sbq [$];
   exp_t e;
   int errors = 0, checks = 0, stall = 0, acc = 0, b, p;
   logic mon_en = 1'b0;
   logic [31:0] last_rd = '0;
   always #5 clk = ~clk;
   sram_ctrl_param u_dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .sram_dq(sram_dq), .sram_addr(sram_addr),
      .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n)
   );
   sram_ctrl_param #(.SRAM_DW(32), .WAIT_CYCLES(5)) u_dut2 (
      .clk(clk), .rst(rst), .rd_en(rd2), .wr_en(1'b0), .addr(addr2), .wdata(32'h0),
      .rdata(rdata2), .ready(ready2), .sram_dq(dq2), .sram_addr(sa2),
      .sram_we_n(we2_n), .sram_oe_n(oe2_n), .sram_ce_n(ce2_n)
   );
   assign sram_dq = (!sram_ce_n && !sram_oe_n) ? mem16[sram_addr] : 'z;
   assign dq2 = (!ce2_n && !oe2_n) ? mem32[sa2] : 'z;
   always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem16[sram_addr] <= sram_dq;
   always @(posedge clk) if (!ce2_n && !we2_n) mem32[sa2] <= dq2;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [17:0] exp_sa(logic [31:0] a, int beat);
      return 18'(((a - 32'd1024) >> 2) * BEATS + beat);
   endfunction
   task automatic do_req(bit rd, bit wr, logic [31:0] a, logic [31:0] d, int gap);
      exp_t x;
      bit ok = 1'b0;
      x.rd = rd;
      x.a  = a;
      x.d  = rd ? ref_m[a] : d;
      if (!rd) ref_m[a] = d;
      sbq.push_back(x);
      rd_en = rd;
      wr_en = wr;
      addr  = a;
      wdata = d;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("done_timeout", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      wr_en = 1'b0;
      addr  = $urandom;
      wdata = $urandom;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask
   always @(negedge clk) begin
      if (rst || !mon_en) begin
         stall = 0;
         acc   = 0;
      end else begin
         if (!sram_ce_n) begin
            if (sbq.size() == 0) chk("access_without_request", 32'd1, 32'd0);
            else begin
               e = sbq[0];
               b = acc / W;
               p = acc % W;
               chk("sram_addr", 32'(sram_addr), 32'(exp_sa(e.a, b)));
               chk("we_n", 32'(sram_we_n), (!e.rd && p < W - 1) ? 32'd0 : 32'd1);
               chk("oe_n", 32'(sram_oe_n), e.rd ? 32'd0 : 32'd1);
               chk("dq_beat", 32'(sram_dq), 32'(e.d[b*16 +: 16]));
            end
            acc++;
         end else begin
            chk("idle_strobes", 32'({sram_we_n, sram_oe_n}), 32'd3);
            chk("idle_dq_z", 32'(sram_dq), 32'hFFFF);
         end
         if (!ready) stall++;
         if ((rd_en || wr_en) && ready) begin
            if (sbq.size() == 0) chk("done_without_request", 32'd1, 32'd0);
            else begin
               e = sbq.pop_front();
               chk("stall_cycles", 32'(stall), 32'(N + 1));
               chk("access_cycles", 32'(acc), 32'(N));
               chk(e.rd ? "rdata" : "rdata_kept", rdata, e.rd ? e.d : last_rd);
               if (e.rd) last_rd = e.d;
            end
            stall = 0;
            acc   = 0;
         end
      end
   end
   initial begin
      int unsigned win [8] = '{1028, 1032, 1036, 1040, 1044, 1048, 0, 1020};
      logic [31:0] v;
      int st, oe, bad;
      bit ok;
      rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; rd2 = 1'b0; addr2 = '0;
      mem32[1] = 32'h12345678;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_strobes", 32'({sram_we_n, sram_oe_n, sram_ce_n}), 32'd7);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_dq_z", 32'(sram_dq), 32'hFFFF);
      chk("rst_rdata2", rdata2, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_ready", 32'(ready), 32'd1);
      mon_en = 1'b1;
      do_req(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1);
      chk("mem_word0", 32'(mem16[0]), 32'hBEEF);
      chk("mem_word1", 32'(mem16[1]), 32'hDEAD);
      do_req(1'b1, 1'b0, 32'd1024, 32'h0, 0);
      foreach (win[k]) do_req(1'b0, 1'b1, win[k], $urandom, k % 2);
      do_req(1'b1, 1'b1, win[1], $urandom, 1);
      mon_en = 1'b0;
      wr_en = 1'b1;
      addr  = 32'd1032;
      wdata = 32'hCAFEF00D;
      @(negedge clk);
      @(negedge clk);
      chk("abort_we_low", 32'(sram_we_n), 32'd0);
      rst = 1'b1;
      #1;
      chk("abort_strobes", 32'({sram_we_n, sram_ce_n}), 32'd3);
      chk("abort_dq_z", 32'(sram_dq), 32'hFFFF);
      chk("abort_rdata", rdata, 32'd0);
      wr_en = 1'b0;
      #1;
      chk("abort_ready", 32'(ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      last_rd = '0;
      v = ref_m[32'd1032];
      chk("abort_no_write", 32'(mem16[4]), 32'(v[15:0]));
      mon_en = 1'b1;
      do_req(1'b1, 1'b0, 32'd1032, 32'h0, 0);
      repeat (40) begin
         int k, op;
         k  = $urandom_range(0, 7);
         op = $urandom_range(0, 2);
         do_req(op != 1, op != 0, win[k], $urandom, $urandom_range(0, 2));
      end
      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      mon_en = 1'b0;
      rd2 = 1'b1;
      addr2 = 32'd1028;
      st = 0; oe = 0; bad = 0; ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ready2) begin
            ok = 1'b1;
            break;
         end
         st++;
         if (!oe2_n) begin
            oe++;
            if (sa2 != 18'd1) bad++;
         end
      end
      chk("w32_done", 32'(ok), 32'd1);
      chk("w32_stall", 32'(st), 32'd6);
      chk("w32_oe_cycles", 32'(oe), 32'd5);
      chk("w32_addr_errs", 32'(bad), 32'd0);
      chk("w32_rdata", rdata2, 32'h12345678);
      @(posedge clk);
      #1;
      rd2 = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sram_ctrl_param.md
# sram_ctrl_param

Parametrised SRAM controller between the MEM stage and an external asynchronous SRAM. It serves single 32-bit loads and stores. The SRAM data bus may be 16 or 32 bits wide; a 16-bit bus takes two beats per access. Wait states per beat are configurable. `ready` is low while the pipeline must stall.

## Interface
Parameters:
- `SRAM_DW`, default 16: SRAM data bus width. Legal values are 16 and 32. `BEATS` = 32/`SRAM_DW`.
- `SRAM_AW`, default 18: SRAM address width.
- `WAIT_CYCLES`, default 2: clock cycles per beat. Must be ≥ 2.
- `BASE_ADDR`, default 1024: CPU byte address that maps to SRAM word 0.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `rd_en`, in, 1: load request. Held high by the CPU until `ready`.
- `wr_en`, in, 1: store request. Held high by the CPU until `ready`.
- `addr`, in, 32: CPU byte address, word aligned.
- `wdata`, in, 32: store data.
- `rdata`, out, 32: load data. Registered; valid from DONE onward.
- `ready`, out, 1: high means no stall is needed.
- `sram_dq`, inout, `SRAM_DW`: SRAM data bus.
- `sram_addr`, out, `SRAM_AW`: SRAM word address.
- `sram_we_n`, out, 1: write enable, active low.
- `sram_oe_n`, out, 1: output enable, active low.
- `sram_ce_n`, out, 1: chip enable, active low.

## Operation
- States:
  - IDLE: no access in progress.
  - ACCESS: SRAM beats in progress.
  - DONE: one cycle; the access has completed.
- IDLE → ACCESS when `rd_en | wr_en`. On that edge the block latches:
  - `op` (read wins if both requests are high),
  - `off` = (`addr` − `BASE_ADDR`) >> 2, 32-bit modulo subtraction,
  - `wdata`.
- ACCESS uses two counters:
  - `wcnt` counts 0..`WAIT_CYCLES`−1. It resets to 0 at each beat boundary.
  - `beat` counts 0..`BEATS`−1.
- ACCESS → DONE when `wcnt == WAIT_CYCLES−1` and `beat == BEATS−1`.
- DONE → IDLE unconditionally. A request sampled in DONE is not started there; it is started from IDLE.
- Address: `sram_addr` = (`off` × `BEATS` + `beat`), truncated to `SRAM_AW` bits.
  - Address wrap-around is silent.
  - `addr` below `BASE_ADDR` wraps.
- Beat order: beat 0 carries bits [`SRAM_DW`−1:0]; beat 1 carries bits [31:16].
- Write access:
  - `sram_dq` is driven with the beat's slice during every ACCESS cycle.
  - `sram_we_n` is 0 while `wcnt < WAIT_CYCLES−1`, and 1 on the last cycle of each beat (hold cycle).
  - `sram_oe_n` stays 1.
- Read access:
  - `sram_oe_n` = 0 throughout ACCESS.
  - `sram_dq` is high-Z.
  - The beat's slice of `rdata` is captured from `sram_dq` on the clock edge that ends the beat's last cycle.
- `sram_ce_n` = 0 only in ACCESS.
- `rdata` holds its value until the next read overwrites it. A write never changes `rdata`.
- `sram_dq` is high-Z in every state other than a write ACCESS.

## Timing
- Reset values:
  - state IDLE; `wcnt`, `beat`, `off`, `rdata` = 0.
  - `sram_addr` = 0.
  - `sram_we_n`, `sram_oe_n`, `sram_ce_n` = 1.
  - `sram_dq` = Z; `ready` = 1.
- `ready` is combinational:
  - low when state is ACCESS,
  - low when state is IDLE with `rd_en | wr_en`,
  - high otherwise.
- Request first seen at cycle 0:
  - ACCESS spans cycles 1..N, where N = `BEATS`×`WAIT_CYCLES`.
  - DONE is cycle N+1.
  - Stall = N+1 cycles. With defaults N = 4, so `ready` is low for cycles 0–4.
- In DONE, `ready` = 1 and `rdata` is already valid. The CPU advances on that edge.
- Back-to-back requests: the next request is seen in IDLE at cycle N+2, so there is one bubble cycle.
- Reset mid-access aborts immediately (asynchronous):
  - `sram_we_n` and `sram_ce_n` go to 1 and `sram_dq` is released in the same instant.
  - A partial write is not completed.
  - `rdata` clears to 0.
- Request inputs are ignored during ACCESS and DONE.

## Test plan
- Reset with defaults: all outputs at their reset values; `sram_dq` = Z; `ready` = 1 with no request.
- Write `addr`=1024, `wdata`=0xDEADBEEF (defaults):
  - `ready` low for 5 cycles.
  - `sram_addr` 0 then 1, carrying 0xBEEF then 0xDEAD.
  - `sram_we_n` low on one cycle per beat.
- Read from `addr`=1024 after that write: `rdata`=0xDEADBEEF in DONE; `sram_oe_n` low for 4 cycles; `sram_we_n` stays 1.
- `SRAM_DW`=32, `WAIT_CYCLES`=5, read `addr`=1028 with the model holding 0x12345678 at word 1: `sram_addr`=1; `ready` low for 6 cycles; `rdata`=0x12345678.
- `rd_en` and `wr_en` both high: a read is performed and `sram_dq` is never driven.
- Assert `rst` at cycle 2 of a write: `sram_we_n`=1 and `sram_dq`=Z immediately; state IDLE afterwards; the next request completes normally.
